// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with byte-lane writes.
// Optional wait-state insertion is enabled with the APB_SLV_WAIT_EN macro.
module apb_slave_mem #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic [1:0]                fsm_state
);

    // Handshake: a transfer is accepted at the setup edge (PSEL=1, PENABLE=0)
    // and completes at the first edge with PSEL=PENABLE=PREADY=1.

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                   state;
    logic [DATA_WIDTH-1:0]    mem [MEM_DEPTH];
    logic                     lat_write;
    logic                     lat_err;
    logic [MEM_AW-1:0]        lat_idx;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [STRB_W-1:0]        lat_strb;

    logic                     err_now;
    logic [MEM_AW-1:0]        idx_now;

    assign fsm_state = state;

    // Out-of-range addresses may alias a valid index here; err_now blocks every use.
    assign err_now = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR[ADDR_WIDTH-1:2]} >= DEPTH_V);
    assign idx_now = PADDR[MEM_AW+1:2];

`ifdef APB_SLV_WAIT_EN
    localparam int N_WAIT = WAIT_CYCLES;
    localparam int CNT_W  = (N_WAIT > 0) ? $clog2(N_WAIT + 1) : 1;
    logic [CNT_W-1:0] cnt;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= S_IDLE;
            PRDATA    <= '0;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt       <= '0;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        lat_write <= PWRITE;
                        lat_err   <= err_now;
                        lat_idx   <= idx_now;
                        lat_wdata <= PWDATA;
                        lat_strb  <= PSTRB;
`ifdef APB_SLV_WAIT_EN
                        if (N_WAIT == 0) begin
                            state   <= S_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_now;
                            PRDATA  <= (!PWRITE && !err_now) ? mem[idx_now] : '0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(N_WAIT);
                        end
`else
                        state   <= S_READY;
                        PREADY  <= 1'b1;
                        PSLVERR <= err_now;
                        PRDATA  <= (!PWRITE && !err_now) ? mem[idx_now] : '0;
`endif
                    end
                end
`ifdef APB_SLV_WAIT_EN
                S_WAIT: begin
                    if (!PSEL) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(1)) begin
                        state   <= S_READY;
                        cnt     <= '0;
                        PREADY  <= 1'b1;
                        PSLVERR <= lat_err;
                        PRDATA  <= (!lat_write && !lat_err) ? mem[lat_idx] : '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                S_READY: begin
                    if (!PSEL) begin
                        state   <= S_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end else if (PENABLE) begin
                        if (lat_write && !lat_err) begin
                            for (int i = 0; i < STRB_W; i++) begin
                                if (lat_strb[i]) begin
                                    mem[lat_idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
                                end
                            end
                        end
                        state   <= S_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                        PRDATA  <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: reset, full/partial writes, error decode,
// master abort, async reset mid-transfer and an IDLE protocol violation.
module tb_apb_slave_mem;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef APB_SLV_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [1:0]    fsm_state;

    int n_total = 0;
    int n_bad   = 0;

    apb_slave_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (32),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // driver: called and returns at a negedge
    task automatic apb_xfer(input string tag, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                            output logic [DW-1:0] rdata, output logic err, output int waits);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); @(negedge PCLK);
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            @(posedge PCLK); @(negedge PCLK);
            waits++;
        end
        check({tag, "_pready"}, 32'(PREADY), 32'd1);
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); @(negedge PCLK);
        check({tag, "_done"}, {30'd0, PREADY, PSLVERR}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, input logic exp_err);
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        apb_xfer(tag, 1'b1, addr, data, strb, rd, er, w);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_waits"}, 32'(w), 32'(WAITS));
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] addr,
                           input logic [DW-1:0] exp_data, input logic exp_err);
        logic [DW-1:0] rd;
        logic          er;
        int            w;
        apb_xfer(tag, 1'b0, addr, '0, '0, rd, er, w);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        repeat (2) @(negedge PCLK);
        check("rst_out", {PRDATA[29:0], PREADY, PSLVERR}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // basic read after reset, then full write / read back-to-back
        do_read ("rd04", 8'h04, 32'h0000_0000, 1'b0);
        do_write("wr08", 8'h08, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        do_read ("rd08", 8'h08, 32'hDEAD_BEEF, 1'b0);

        // partial strobe over a preset word
        do_write("wr0c_pre", 8'h0C, 32'hAAAA_AAAA, 4'b1111, 1'b0);
        do_write("wr0c_strb", 8'h0C, 32'h1122_3344, 4'b0101, 1'b0);
        do_read ("rd0c", 8'h0C, 32'hAA22_AA44, 1'b0);

        // last valid word, out-of-range and misaligned accesses
        do_write("wr7c", 8'h7C, 32'hCAFE_0001, 4'b1111, 1'b0);
        do_read ("rd7c", 8'h7C, 32'hCAFE_0001, 1'b0);
        do_write("wr80", 8'h80, 32'h1234_5678, 4'b1111, 1'b1);
        do_write("wr02", 8'h02, 32'h1234_5678, 4'b1111, 1'b1);
        do_read ("rd80", 8'h80, 32'h0000_0000, 1'b1);
        do_read ("rd02", 8'h02, 32'h0000_0000, 1'b1);
        do_read ("rd00", 8'h00, 32'h0000_0000, 1'b0);
        do_read ("rd08_again", 8'h08, 32'hDEAD_BEEF, 1'b0);

        // master abort: write to 0x10 dropped before completion
        do_write("wr10", 8'h10, 32'h0101_0101, 4'b1111, 1'b0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'b1111;
        @(posedge PCLK); @(negedge PCLK);
`ifdef APB_SLV_WAIT_EN
        PENABLE = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
`endif
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); @(negedge PCLK);
        check("abort_pready", 32'(PREADY), 32'd0);
        check("abort_state", 32'(fsm_state), 32'd0);
        do_read ("rd10", 8'h10, 32'h0101_0101, 1'b0);

        // IDLE protocol violation: PSEL and PENABLE together without setup
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h18;
        PWDATA = 32'h0000_0077; PSTRB = 4'b1111;
        @(posedge PCLK); @(negedge PCLK);
        check("viol_pready", 32'(PREADY), 32'd0);
        check("viol_state", 32'(fsm_state), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        do_read ("rd18", 8'h18, 32'h0000_0000, 1'b0);

        // async reset in the middle of a write to 0x14
        do_write("wr14", 8'h14, 32'h5555_5555, 4'b1111, 1'b0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h14;
        PWDATA = 32'h9999_9999; PSTRB = 4'b1111;
        @(posedge PCLK); @(negedge PCLK);
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        #1;
        check("arst_pready", 32'(PREADY), 32'd0);
        check("arst_pslverr", 32'(PSLVERR), 32'd0);
        check("arst_prdata", PRDATA, 32'd0);
        check("arst_state", 32'(fsm_state), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        do_read ("rd14", 8'h14, 32'h0000_0000, 1'b0);
        do_read ("rd08_cleared", 8'h08, 32'h0000_0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
